// File: rtl/shift_reg_pkg.sv
// Shared definitions for the parallel-load / bidirectional shift register.
//   DIR_LEFT / DIR_RIGHT : encoding of the shift_left_right control bit
//   DEFAULT_WIDTH        : default register width
//   op_e / decode_op     : next-state selection derived from the controls
package shift_reg_pkg;

  localparam logic DIR_LEFT      = 1'b0;  // shift toward MSB
  localparam logic DIR_RIGHT     = 1'b1;  // shift toward LSB
  localparam int   DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_LEFT  = 2'd1,
    OP_RIGHT = 2'd2
  } op_e;

  // Load wins over shift. The direction bit is only looked at when not
  // loading, so an unknown direction cannot disturb a load.
  function automatic op_e decode_op(input logic load_enable, input logic dir);
    op_e op;
    if (load_enable) begin
      op = OP_LOAD;
    end else if (dir == DIR_RIGHT) begin
      op = OP_RIGHT;
    end else begin
      op = OP_LEFT;
    end
    return op;
  endfunction

endpackage

// File: rtl/shift_left_right_load_if.sv
// Control / data bundle for shift_left_right_load.
//   load_enable      : 1 = parallel load of i, 0 = shift
//   shift_left_right : 0 = shift left (toward MSB), 1 = shift right
//   i                : parallel load data
//   q                : registered register contents
// master drives the controls and observes q; slave is the register itself.
interface shift_left_right_load_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load_enable;
  logic             shift_left_right;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] q;

  modport master (
    output load_enable,
    output shift_left_right,
    output i,
    input  q
  );

  modport slave (
    input  load_enable,
    input  shift_left_right,
    input  i,
    output q
  );

endinterface

// File: rtl/shift_left_right_load_bit_cell.sv
// One bit slice of the shift register: a 3:1 next-state mux.
//   load_enable_i      : parallel load request
//   shift_left_right_i : direction (DIR_LEFT / DIR_RIGHT)
//   lsb_side_i         : neighbour q[n-1] (0 for bit 0), used by a left shift
//   msb_side_i         : neighbour q[n+1] (0 for the MSB), used by a right shift
//   load_bit_i         : i[n]
//   d_o                : next value for flop n
module shift_bit_cell
  import shift_reg_pkg::*;
(
  input  logic load_enable_i,
  input  logic shift_left_right_i,
  input  logic lsb_side_i,
  input  logic msb_side_i,
  input  logic load_bit_i,
  output logic d_o
);

  op_e op;

  always_comb begin
    op  = decode_op(load_enable_i, shift_left_right_i);
    d_o = 1'b0;
    case (op)
      OP_LOAD:  d_o = load_bit_i;
      OP_LEFT:  d_o = lsb_side_i;
      OP_RIGHT: d_o = msb_side_i;
      default:  d_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_left_right_load.sv
// Parallel-load, bidirectional logical shift register.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears q immediately
//   bus   : slave side of shift_left_right_load_if
//           (load_enable, shift_left_right, i in; q out)
// Every edge either loads i or shifts by one bit; there is no hold state.
// Vacated bits fill with 0 in both directions.
module shift_left_right_load
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_left_right_load_if.slave bus
);

  // Elaboration-time sanity checks.
  if (WIDTH < 2) begin : g_width_check
    $error("shift_left_right_load: WIDTH must be >= 2");
  end
  if ($bits(bus.i) != WIDTH) begin : g_bus_width_check
    $error("shift_left_right_load: interface WIDTH does not match module WIDTH");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic lsb_nb;
      logic msb_nb;

      // End bits take a constant 0 as the shifted-in value.
      if (gi == 0) begin : g_lsb_edge
        assign lsb_nb = 1'b0;
      end else begin : g_lsb_mid
        assign lsb_nb = q_q[gi-1];
      end

      if (gi == WIDTH - 1) begin : g_msb_edge
        assign msb_nb = 1'b0;
      end else begin : g_msb_mid
        assign msb_nb = q_q[gi+1];
      end

      shift_bit_cell u_cell (
        .load_enable_i      (bus.load_enable),
        .shift_left_right_i (bus.shift_left_right),
        .lsb_side_i         (lsb_nb),
        .msb_side_i         (msb_nb),
        .load_bit_i         (bus.i[gi]),
        .d_o                (q_d[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q = q_q;

endmodule

// File: tb/tb_shift_left_right_load.sv
// Directed testbench for shift_left_right_load (WIDTH = 8).
module tb_shift_left_right_load;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;

  int n_compared   = 0;
  int n_mismatched = 0;

  shift_left_right_load_if #(.WIDTH(WIDTH)) bus ();

  shift_left_right_load #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end else begin
      $display("ok   %s: q=%02h", tag, got);
    end
  endtask

  // Advance one rising edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] exp_left  [10];
  logic [WIDTH-1:0] exp_right [8];
  logic [WIDTH-1:0] track_vec [4];

  initial begin
    exp_left  = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00};
    exp_right = '{8'h54, 8'h2A, 8'h15, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
    track_vec = '{8'h11, 8'hE7, 8'h5A, 8'h00};

    reset                = 1'b1;
    bus.load_enable      = 1'b0;
    bus.shift_left_right = 1'b0;
    bus.i                = '0;

    // Reset held across edges.
    tick();
    check_val("reset_hold_0", bus.q, 8'h00);
    tick();
    check_val("reset_hold_1", bus.q, 8'h00);

    // Load 0xFF for 6 edges; release is sampled at the first of them.
    reset           = 1'b0;
    bus.i           = 8'hFF;
    bus.load_enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val($sformatf("load_ff_%0d", k), bus.q, 8'hFF);
    end

    // Shift left from 0xFF, then stays at 0.
    bus.load_enable      = 1'b0;
    bus.shift_left_right = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("shl_%0d", k), bus.q, exp_left[k]);
    end

    // Load 0xA8 then shift right.
    bus.i           = 8'hA8;
    bus.load_enable = 1'b1;
    tick();
    check_val("load_a8", bus.q, 8'hA8);
    bus.load_enable      = 1'b0;
    bus.shift_left_right = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val($sformatf("shr_%0d", k), bus.q, exp_right[k]);
    end

    // Load has priority over the direction bit.
    bus.i           = 8'h3C;
    bus.load_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.shift_left_right = k[0];
      tick();
      check_val($sformatf("prio_load_%0d", k), bus.q, 8'h3C);
    end
    bus.shift_left_right = 1'bx;
    tick();
    check_val("prio_load_dirx", bus.q, 8'h3C);
    bus.shift_left_right = 1'b0;

    // Asynchronous reset mid-cycle during a load: q clears before the edge.
    bus.i = 8'hC3;
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset_mid", bus.q, 8'h00);
    tick();
    check_val("async_reset_edge", bus.q, 8'h00);
    reset = 1'b0;
    tick();
    check_val("reset_release_load", bus.q, 8'hC3);

    // Asynchronous reset mid-shift.
    bus.load_enable = 1'b0;
    tick();
    check_val("shift_before_reset", bus.q, 8'h86);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_reset_shift", bus.q, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Direction switch with no bubble.
    bus.i           = 8'h18;
    bus.load_enable = 1'b1;
    tick();
    check_val("dir_load_18", bus.q, 8'h18);
    bus.load_enable      = 1'b0;
    bus.shift_left_right = 1'b0;
    tick();
    check_val("dir_left_30", bus.q, 8'h30);
    bus.shift_left_right = 1'b1;
    tick();
    check_val("dir_right_18", bus.q, 8'h18);
    tick();
    check_val("dir_right_0c", bus.q, 8'h0C);

    // Continuous load tracks i with one cycle of delay.
    bus.load_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.i = track_vec[k];
      tick();
      check_val($sformatf("track_%0d", k), bus.q, track_vec[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
